// File: rtl/matrix_loader.sv
// matrix_loader: fetches one BANDWIDTH-word chunk of Q2.14 weights from a
// single-port weight SRAM for the matvec multiplier and holds it stable
// after handing it over.
// Optional build macro MATRIX_LOADER_OOB_ERR_EN adds the sticky addr_error
// output that flags requests whose chunk runs past the end of the matrix.
module matrix_loader #(
    parameter int MAX_ROWS     = 64,
    parameter int MAX_COLS     = 64,
    parameter int BANDWIDTH    = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int SRAM_LATENCY = 1,
    localparam int ADDR_W      = $clog2(MAX_ROWS * MAX_COLS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         matrix_enable,
    input  logic [ADDR_W-1:0]            matrix_addr,
    output logic signed [DATA_WIDTH-1:0] matrix_data [0:BANDWIDTH-1],
    output logic                         matrix_ready,
    output logic [ADDR_W-1:0]            sram_addr,
    output logic                         sram_en,
    input  logic [DATA_WIDTH-1:0]        sram_rdata,
`ifdef MATRIX_LOADER_OOB_ERR_EN
    output logic                         addr_error,
`endif
    output logic                         busy
);

    localparam int SUM_W = ADDR_W + 1;
    localparam int IDX_W = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BANDWIDTH - 1);
    localparam logic [SUM_W-1:0] LAST_ADDR = SUM_W'(MAX_ROWS * MAX_COLS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_READY = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  issue_cnt;

    logic [ADDR_W-1:0] issue_base;
    logic [IDX_W-1:0]  issue_k;
    logic [SUM_W-1:0]  issue_sum;
    logic              issue_oob;
    logic              do_issue;

    // In-flight tags: stage 0 lines up with the registered sram_en, stage
    // SRAM_LATENCY lines up with the returning sram_rdata word.
    logic              pipe_v   [0:SRAM_LATENCY];
    logic [IDX_W-1:0]  pipe_idx [0:SRAM_LATENCY];
    logic              pipe_oob [0:SRAM_LATENCY];
    logic              pipe_busy;
    logic              capture_ok;
    logic              last_capture;

    assign busy = (state != S_IDLE);

    // Pick the slot issued at this edge; the accepting edge in IDLE issues
    // word 0 straight from the live request address.
    always_comb begin
        issue_base = base;
        issue_k    = issue_cnt;
        if (state == S_IDLE) begin
            issue_base = matrix_addr;
            issue_k    = '0;
        end
        issue_sum = {1'b0, issue_base} + SUM_W'(issue_k);
        issue_oob = (issue_sum > LAST_ADDR);
        do_issue  = matrix_enable && ((state == S_IDLE) || (state == S_ISSUE));
    end

    // Returning words are only kept while the request is still live, so an
    // abort or a drain discards them without touching matrix_data.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i <= SRAM_LATENCY; i++) begin
            pipe_busy = pipe_busy | pipe_v[i];
        end
        capture_ok   = pipe_v[SRAM_LATENCY] && matrix_enable &&
                       ((state == S_ISSUE) || (state == S_FILL));
        last_capture = capture_ok && (pipe_idx[SRAM_LATENCY] == LAST_IDX);
    end

    // Request sequencing: accept, issue, wait for the last word, hand over,
    // and drain outstanding reads after an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            base         <= '0;
            issue_cnt    <= '0;
            matrix_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (matrix_enable) begin
                        base      <= matrix_addr;
                        issue_cnt <= issue_k + 1'b1;
                        state     <= (issue_k == LAST_IDX) ? S_FILL : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!matrix_enable) begin
                        state <= S_DRAIN;
                    end else begin
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == LAST_IDX) begin
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (!matrix_enable) begin
                        state <= S_DRAIN;
                    end else if (last_capture) begin
                        matrix_ready <= 1'b1;
                        state        <= S_READY;
                    end
                end
                S_READY: begin
                    if (!matrix_enable) begin
                        matrix_ready <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (!pipe_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    matrix_ready <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

    // SRAM strobe and address; out-of-range slots keep the strobe low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_en   <= 1'b0;
            sram_addr <= '0;
        end else begin
            sram_en <= do_issue && !issue_oob;
            if (do_issue) begin
                sram_addr <= issue_sum[ADDR_W-1:0];
            end
        end
    end

    // Tag pipe: every issue slot, in range or not, travels down the pipe so
    // zero-filled words land on the same edge a real read would.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= SRAM_LATENCY; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_idx[i] <= '0;
                pipe_oob[i] <= 1'b0;
            end
        end else begin
            pipe_v[0]   <= do_issue;
            pipe_idx[0] <= issue_k;
            pipe_oob[0] <= issue_oob;
            for (int i = 1; i <= SRAM_LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
                pipe_oob[i] <= pipe_oob[i-1];
            end
        end
    end

    // Chunk storage; only written by a live capture so the multiplier can
    // keep reading it after it drops enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BANDWIDTH; i++) begin
                matrix_data[i] <= '0;
            end
        end else if (capture_ok) begin
            matrix_data[pipe_idx[SRAM_LATENCY]] <=
                pipe_oob[SRAM_LATENCY] ? '0 : $signed(sram_rdata);
        end
    end

`ifdef MATRIX_LOADER_OOB_ERR_EN
    logic [SUM_W-1:0] span_end;
    assign span_end = {1'b0, matrix_addr} + SUM_W'(BANDWIDTH - 1);

    // Sticky range flag, refreshed by every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_error <= 1'b0;
        end else if ((state == S_IDLE) && matrix_enable) begin
            addr_error <= (span_end > LAST_ADDR);
        end
    end
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: drives two matrix_loader instances (SRAM latency 1 and 3)
// with the same requests. Stimulus pushes expected SRAM issues and expected
// chunks into queues; a negedge monitor pops and compares them.
module tb_matrix_loader;

    localparam int BW    = 16;
    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int WORDS = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic matrix_enable = 1'b0;
    logic [AW-1:0] matrix_addr = '0;

    logic signed [DW-1:0] data1 [0:BW-1];
    logic signed [DW-1:0] data3 [0:BW-1];
    logic ready1, ready3, sram_en1, sram_en3, busy1, busy3;
    logic [AW-1:0] sram_addr1, sram_addr3;
    logic [DW-1:0] rdata1, rdata3;
    logic [BW*DW-1:0] flat1, flat3;
    logic prev1 = 1'b0;
    logic prev3 = 1'b0;
`ifdef MATRIX_LOADER_OOB_ERR_EN
    logic err1, err3;
`endif

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    int iss_c1[$], iss_a1[$], iss_c3[$], iss_a3[$];
    int rdy_c1[$], rdy_c3[$];
    logic [BW*DW-1:0] rdy_d1[$], rdy_d3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matrix_loader #(.SRAM_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .matrix_enable(matrix_enable),
        .matrix_addr(matrix_addr), .matrix_data(data1), .matrix_ready(ready1),
        .sram_addr(sram_addr1), .sram_en(sram_en1), .sram_rdata(rdata1),
`ifdef MATRIX_LOADER_OOB_ERR_EN
        .addr_error(err1),
`endif
        .busy(busy1));

    matrix_loader #(.SRAM_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .matrix_enable(matrix_enable),
        .matrix_addr(matrix_addr), .matrix_data(data3), .matrix_ready(ready3),
        .sram_addr(sram_addr3), .sram_en(sram_en3), .sram_rdata(rdata3),
`ifdef MATRIX_LOADER_OOB_ERR_EN
        .addr_error(err3),
`endif
        .busy(busy3));

    // SRAM models: word content equals its address
    logic [DW-1:0] mem1_q = '0;
    logic [DW-1:0] mem3_q [0:2];
    always @(posedge clk) begin
        mem1_q    <= sram_en1 ? DW'(sram_addr1) : 16'hBEEF;
        mem3_q[0] <= sram_en3 ? DW'(sram_addr3) : 16'hBEEF;
        mem3_q[1] <= mem3_q[0];
        mem3_q[2] <= mem3_q[1];
    end
    assign rdata1 = mem1_q;
    assign rdata3 = mem3_q[2];

    for (genvar g = 0; g < BW; g++) begin : g_flat
        assign flat1[g*DW +: DW] = data1[g];
        assign flat3[g*DW +: DW] = data3[g];
    end

    function automatic logic [DW-1:0] chunkWord(input int base, input int i);
        int a;
        a = base + i;
        return (a < WORDS) ? DW'(a) : '0;
    endfunction

    function automatic logic [BW*DW-1:0] chunk(input int base);
        logic [BW*DW-1:0] v;
        v = '0;
        for (int i = 0; i < BW; i++) v[i*DW +: DW] = chunkWord(base, i);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Issue a request at this negedge and record what both DUTs owe us
    task automatic applyStimulus(input int base, input int n_issue, input bit exp_ready);
        int c;
        c = cyc;
        matrix_enable = 1'b1;
        matrix_addr   = AW'(base);
        for (int k = 0; k < n_issue; k++) begin
            if (base + k < WORDS) begin
                iss_c1.push_back(c + 1 + k); iss_a1.push_back(base + k);
                iss_c3.push_back(c + 1 + k); iss_a3.push_back(base + k);
            end
        end
        if (exp_ready) begin
            rdy_c1.push_back(c + 18); rdy_d1.push_back(chunk(base));
            rdy_c3.push_back(c + 20); rdy_d3.push_back(chunk(base));
        end
        @(negedge clk);
        matrix_addr = AW'(12'h555);
    endtask

    task automatic monitorDut(input int id);
        logic en, rdy, prv;
        logic [AW-1:0] addr;
        logic [BW*DW-1:0] flat, ed;
        int ec, ea, qsz, rsz;
        string tag;
        if (id == 1) begin
            en = sram_en1; rdy = ready1; prv = prev1; addr = sram_addr1; flat = flat1;
            qsz = iss_c1.size(); rsz = rdy_c1.size(); tag = "L1";
        end else begin
            en = sram_en3; rdy = ready3; prv = prev3; addr = sram_addr3; flat = flat3;
            qsz = iss_c3.size(); rsz = rdy_c3.size(); tag = "L3";
        end
        if (en) begin
            if (qsz == 0) begin
                checkOutput({tag, " unexpected sram_en"}, 64'(en), 64'd0);
            end else begin
                if (id == 1) begin ec = iss_c1.pop_front(); ea = iss_a1.pop_front(); end
                else         begin ec = iss_c3.pop_front(); ea = iss_a3.pop_front(); end
                checkOutput({tag, " sram issue cycle"}, 64'(cyc), 64'(ec));
                checkOutput({tag, " sram_addr"}, 64'(addr), 64'(ea));
            end
        end
        if (rdy && !prv) begin
            if (rsz == 0) begin
                checkOutput({tag, " unexpected matrix_ready"}, 64'(rdy), 64'd0);
            end else begin
                if (id == 1) begin ec = rdy_c1.pop_front(); ed = rdy_d1.pop_front(); end
                else         begin ec = rdy_c3.pop_front(); ed = rdy_d3.pop_front(); end
                checkOutput({tag, " ready cycle"}, 64'(cyc), 64'(ec));
                for (int i = 0; i < BW; i++)
                    checkOutput($sformatf("%s data[%0d]", tag, i),
                                64'(flat[i*DW +: DW]), 64'(ed[i*DW +: DW]));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            monitorDut(1);
            monitorDut(3);
        end
    end
    always @(negedge clk) begin
        prev1 <= ready1;
        prev3 <= ready3;
    end

    task automatic checkReset();
        checkOutput("reset ready",     64'({ready1, ready3}), 64'd0);
        checkOutput("reset sram_en",   64'({sram_en1, sram_en3}), 64'd0);
        checkOutput("reset sram_addr", 64'({sram_addr1, sram_addr3}), 64'd0);
        checkOutput("reset busy",      64'({busy1, busy3}), 64'd0);
        checkOutput("reset data L1",   64'(flat1 != '0), 64'd0);
        checkOutput("reset data L3",   64'(flat3 != '0), 64'd0);
`ifdef MATRIX_LOADER_OOB_ERR_EN
        checkOutput("reset addr_error", 64'({err1, err3}), 64'd0);
`endif
    endtask

    task automatic checkData(input string name, input int base);
        for (int i = 0; i < BW; i++) begin
            checkOutput($sformatf("%s L1[%0d]", name, i), {48'd0, data1[i]}, 64'(chunkWord(base, i)));
            checkOutput($sformatf("%s L3[%0d]", name, i), {48'd0, data3[i]}, 64'(chunkWord(base, i)));
        end
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (!(ready1 && ready3) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready within budget", 64'({ready1, ready3}), 64'd3);
    endtask

    task automatic dropEnable();
        matrix_enable = 1'b0;
        @(negedge clk);
        checkOutput("ready fall", 64'({ready1, ready3}), 64'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkReset();
        rst_n = 1'b1;
        @(negedge clk);

        // base 0, then base 16 on the edge after the drop, then base 64
        applyStimulus(0, 16, 1);
        waitReady();
        dropEnable();
        applyStimulus(16, 16, 1);
        waitReady();
        dropEnable();
        applyStimulus(64, 16, 1);
        waitReady();
        dropEnable();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkData("hold64", 64);
        end

        // chunk running past the end of the matrix
        applyStimulus(4090, 16, 1);
`ifdef MATRIX_LOADER_OOB_ERR_EN
        checkOutput("addr_error set", 64'({err1, err3}), 64'd3);
`endif
        waitReady();
        dropEnable();

        // abort at T+5: no ready, prior chunk intact
        applyStimulus(4090, 5, 0);
        repeat (4) @(negedge clk);
        matrix_enable = 1'b0;
        @(negedge clk);
        checkOutput("drain busy", 64'({busy1, busy3}), 64'd3);
        for (int n = 0; n < 10 && (busy1 || busy3); n++) @(negedge clk);
        checkOutput("idle after drain", 64'({busy1, busy3}), 64'd0);
        checkOutput("abort ready", 64'({ready1, ready3}), 64'd0);
        checkData("after abort", 4090);

        // reset in the middle of a fetch
        applyStimulus(64, 8, 0);
`ifdef MATRIX_LOADER_OOB_ERR_EN
        checkOutput("addr_error clear", 64'({err1, err3}), 64'd0);
`endif
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        matrix_enable = 1'b0;
        #1 checkReset();
        iss_c1.delete(); iss_a1.delete(); iss_c3.delete(); iss_a3.delete();
        rdy_c1.delete(); rdy_d1.delete(); rdy_c3.delete(); rdy_d3.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(32, 16, 1);
        waitReady();
        dropEnable();

        repeat (5) @(negedge clk);
        checkOutput("pending expectations",
                    64'(iss_c1.size() + iss_c3.size() + rdy_c1.size() + rdy_c3.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Serves the matvec multiplier's matrix request port: on a request, fetches BANDWIDTH consecutive Q2.14 weight words from a single-port, one-word-wide weight SRAM.
- Assembles the words into a parallel chunk and asserts ready.
- Holds the chunk stable so the multiplier can consume it during its MAC phase after dropping enable.
- Sits between the weight SRAM and the multiplier's matrix_addr / matrix_enable / matrix_data / matrix_ready interface.

Parameters:
- MAX_ROWS, 64, maximum matrix rows.
- MAX_COLS, 64, maximum matrix columns.
- BANDWIDTH, 16, words per chunk delivered to the multiplier.
- DATA_WIDTH, 16, bits per weight word (Q2.14).
- SRAM_LATENCY, 1, cycles from the sram_en sample edge to sram_rdata valid; legal range 1..4.
- ADDR_W, $clog2(MAX_ROWS*MAX_COLS), derived word-address width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- matrix_enable  in  1  request from multiplier; level, held high until ready seen.
- matrix_addr  in  ADDR_W  base word address of the chunk; sampled on request accept.
- matrix_data  out  DATA_WIDTH x BANDWIDTH (signed, unpacked [0:BANDWIDTH-1])  assembled chunk; element i = word at base+i.
- matrix_ready  out  1  chunk complete and valid.
- sram_addr  out  ADDR_W  registered SRAM read address.
- sram_en  out  1  registered SRAM read strobe.
- sram_rdata  in  DATA_WIDTH  SRAM read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; matrix_ready=0; sram_en=0; sram_addr=0; busy=0; all matrix_data elements=0; issue/capture counters and the in-flight pipe cleared. Reset mid-fetch abandons everything; SRAM returns arriving after reset release are ignored.
- States: IDLE, ISSUE, FILL, READY, DRAIN.
- IDLE:
  - matrix_enable sampled high at edge T: latch base=matrix_addr, go to ISSUE.
  - matrix_data keeps its previous contents.
- ISSUE:
  - sram_en=1 with sram_addr=base+k in cycle T+1+k, for k=0..BANDWIDTH-1.
  - Go to FILL after the last issue.
- Capture:
  - A BANDWIDTH-entry valid/index shift pipe of depth SRAM_LATENCY tags each issued read.
  - The word captured at the edge ending cycle T+1+k+SRAM_LATENCY is written to matrix_data[k].
- Out of range (base+k > MAX_ROWS*MAX_COLS-1):
  - No SRAM read is issued; sram_en=0 in that slot.
  - matrix_data[k] is written 0 through the same pipe slot, so timing is unchanged.
- FILL:
  - After the last capture, set matrix_ready=1 and go to READY.
  - First ready cycle is T+BANDWIDTH+SRAM_LATENCY+1 (T+18 at defaults).
- READY:
  - matrix_ready stays high while matrix_enable is high.
  - matrix_enable low at an edge: matrix_ready=0 on the next cycle, go to IDLE.
  - matrix_data is held unchanged until the next request's first capture. This is required because the multiplier reads matrix_data with enable low.
- Abort (matrix_enable low while in ISSUE or FILL):
  - Stop issuing immediately.
  - Go to DRAIN until the in-flight pipe is empty; returning words are discarded and matrix_data is not written.
  - Then go to IDLE. matrix_ready never asserts for an aborted request.
  - A new request arriving during DRAIN waits until IDLE.
- Back-to-back requests: enable falling then rising on consecutive edges is legal. The new request is accepted from IDLE at the second edge.
- matrix_addr changes while busy are ignored; base is latched once per request.
- sram_en is never high in IDLE, READY or DRAIN.

Optional Feature:
- Macro: MATRIX_LOADER_OOB_ERR_EN.
- Defined: adds output addr_error (1 bit, reset 0). It is a sticky flag set in the cycle after any accepted request whose chunk spans beyond MAX_ROWS*MAX_COLS-1. It is cleared only by reset or by the next accepted in-range request.
- Not defined: the port does not exist. Out-of-range words are silently zero-filled either way.

Test Plan:
- Defaults, SRAM word = address; request base 0 at T → 16 consecutive sram_en cycles with addresses 0..15; matrix_ready at T+18; matrix_data[i]=i.
- SRAM_LATENCY=3, base 64 → ready at T+20; matrix_data[i]=64+i; drop enable → ready 0 next cycle; data unchanged for 10 further cycles.
- Base 4090 → reads issued for 4090..4095 only; matrix_data[6..15]=0; with the macro defined, addr_error=1 the cycle after accept.
- Drop enable at T+5 → no further sram_en; state DRAIN then IDLE; matrix_ready stays 0; prior matrix_data unchanged.
- Assert rst_n=0 at T+8 → all outputs 0 asynchronously; after release, a fresh request at base 32 completes normally with correct data.
- Back-to-back: chunk at base 0, then base 16 requested the edge after enable drop → second chunk correct, ready at accept+18.
